load_store_unit: RTL

Memory stage of the 3-stage RISC-V core. It sits directly downstream of data_path's execute stage and consumes the computed address, the store data and the load/store decode.
- Drives a word-addressed data memory through a valid/ready request channel and an rvalid response channel.
- Aligns store bytes and generates byte strobes.
- Extracts and sign- or zero-extends load data.
- Hands load results to writeback.

---
 rtl/load_store_unit_pkg.sv | 75 +++++++
 rtl/load_store_unit_if.sv | 55 +++++
 rtl/load_store_unit_load_align.sv | 36 +++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 codes, FSM
// states, exception causes and the accept-time decode helpers.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        EXC_NONE           = 2'b00,
        EXC_LOAD_MISALIGN  = 2'b01,
        EXC_STORE_MISALIGN = 2'b10,
        EXC_ILLEGAL        = 2'b11
    } exc_cause_t;

    // Opcode/size combinations the unit cannot execute at all.
    function automatic logic lsu_is_illegal(input logic is_load, input logic is_store,
                                            input logic [2:0] funct3);
        logic bad;
        bad = 1'b0;
        if (is_load == is_store)
            bad = 1'b1;
        else if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            bad = 1'b1;
        else if (is_store && (funct3 >= 3'b011))
            bad = 1'b1;
        return bad;
    endfunction

    // Size is carried in funct3[1:0] for both loads and stores.
    function automatic logic lsu_is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (funct3[1:0] == 2'b01)
            mis = addr_lo[0];
        else if (funct3[1:0] == 2'b10)
            mis = (addr_lo != 2'b00);
        return mis;
    endfunction

    function automatic logic [3:0] lsu_store_strb(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the store value across all lanes; the strobes pick the lane.
    function automatic logic [XLEN-1:0] lsu_store_data(input logic [2:0] funct3, input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] data;
        case (funct3[1:0])
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side op channel, data-memory channel, writeback and exception
// outputs of the load/store unit. The slave modport is the LSU's view;
// the master modport is the surrounding core/memory view.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_load;
    logic            ex_is_store;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr;
    logic [XLEN-1:0] ex_wdata;
    logic [4:0]      ex_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            exc_valid;
    logic [1:0]      exc_cause;
    logic [XLEN-1:0] exc_addr;

    logic            busy;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output ex_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output wb_valid, wb_rd, wb_data,
        output exc_valid, exc_cause, exc_addr,
        output busy
    );

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  ex_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  wb_valid, wb_rd, wb_data,
        input  exc_valid, exc_cause, exc_addr,
        input  busy
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extract: picks the byte/half selected by the low
// address bits and sign- or zero-extends it according to funct3.
module load_store_unit_load_align
    import load_store_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection then extension.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_rdata;
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the 3-stage core: accepts one load/store from execute,
// checks legality/alignment, issues a single word request to data memory,
// and returns extended load data to writeback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new op; faulting ops are reported from here
// REQ     | request presented to memory, held until mem_req_ready
// RESP    | load issued, waiting for mem_rvalid
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    lsu_state_t r_state;
    lsu_state_t w_state_nxt;

    logic            w_accept;
    logic            w_illegal;
    logic            w_misalign;
    logic            w_fault;
    logic [1:0]      w_cause;
    logic            w_ex_ready;
    logic            w_req_valid;
    logic            w_busy;
    logic            w_resp_done;
    logic [XLEN-1:0] w_load_data;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wstrb;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_is_store;

    logic            r_exc_valid;
    logic [1:0]      r_exc_cause;
    logic [XLEN-1:0] r_exc_addr;

    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    assign w_illegal   = lsu_is_illegal(bus.ex_is_load, bus.ex_is_store, bus.ex_funct3);
    assign w_misalign  = lsu_is_misaligned(bus.ex_funct3, bus.ex_addr[1:0]);
    assign w_fault     = w_illegal | w_misalign;
    assign w_cause     = w_illegal      ? EXC_ILLEGAL :
                         bus.ex_is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
    assign w_accept    = bus.ex_valid && (r_state == ST_IDLE);
    // rvalid only counts while a load is outstanding.
    assign w_resp_done = (r_state == ST_RESP) && bus.mem_rvalid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ex_ready  = 1'b0;
        w_req_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_ex_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.ex_valid && !w_fault)
                    w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (bus.mem_req_ready)
                    w_state_nxt = r_is_store ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (bus.mem_rvalid)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the op on a legal accept; these hold the request stable in REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_is_store <= 1'b0;
        end else if (w_accept && !w_fault) begin
            r_addr     <= bus.ex_addr;
            r_wdata    <= lsu_store_data(bus.ex_funct3, bus.ex_wdata);
            r_wstrb    <= bus.ex_is_store ? lsu_store_strb(bus.ex_funct3, bus.ex_addr[1:0]) : 4'b0000;
            r_funct3   <= bus.ex_funct3;
            r_rd       <= bus.ex_rd;
            r_is_store <= bus.ex_is_store;
        end
    end

    // Single-cycle exception pulse the cycle after a faulting accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= 2'b00;
            r_exc_addr  <= '0;
        end else begin
            r_exc_valid <= w_accept && w_fault;
            if (w_accept && w_fault) begin
                r_exc_cause <= w_cause;
                r_exc_addr  <= bus.ex_addr;
            end
        end
    end

    load_store_unit_load_align u_load_align (
        .i_rdata   (bus.mem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // Single-cycle writeback pulse the cycle after rvalid in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_resp_done;
            if (w_resp_done) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

    assign bus.ex_ready      = w_ex_ready;
    assign bus.busy          = w_busy;
    assign bus.mem_req_valid = w_req_valid;
    assign bus.mem_we        = r_is_store;
    assign bus.mem_addr      = {r_addr[XLEN-1:2], 2'b00};
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_wstrb     = r_wstrb;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.exc_valid     = r_exc_valid;
    assign bus.exc_cause     = r_exc_cause;
    assign bus.exc_addr      = r_exc_addr;

endmodule
